// File: rtl/uart_rx_engine.sv
// uart_rx_engine
//   UART receive engine: 2-flop synchroniser, start-edge detect with mid-bit
//   validation, runtime baud divisor, 7/8 data bits, optional even/odd
//   parity, framing/parity/overrun flags and a ready/ack read handshake.
// Ports:
//   clk, rst        clock, async active-high reset
//   rx              serial input (async, idles high)
//   baud_val        clocks per bit (>= 4)
//   eight/pen/ohel  8-bit select, parity enable, odd parity select
//   rd_ack          one-cycle pulse consuming the held frame
//   rx_data         received byte (bit 7 = 0 in 7-bit mode)
//   rx_rdy          frame held and unread
//   perr/ferr/ovf   parity/framing/overrun flags of the held frame
//   busy            engine not idle
module uart_rx_engine #(
  parameter int DIV_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [DIV_W-1:0] baud_val,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             rd_ack,
  output logic [7:0]       rx_data,
  output logic             rx_rdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf,
  output logic             busy
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_COMMIT = 3'd4
  } state_t;

  // frame configuration, frozen at the start edge
  typedef struct packed {
    logic [DIV_W-1:0] baud;
    logic             eight;
    logic             pen;
    logic             ohel;
  } cfg_t;

  state_t           state;
  cfg_t             cfg;
  logic             rx_m, rxs, rxs_d;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bcnt;
  logic [8:0]       sr;
  logic             stop_bit;

  // synchroniser plus history flop; all preset to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_m  <= rx;
      rxs   <= rx_m;
      rxs_d <= rxs;
    end
  end

  logic             start_edge;
  logic [3:0]       nbits;
  logic             half_tc, bit_tc, last_bit;
  logic [8:0]       aligned;
  logic [7:0]       data_w;
  logic             par_bit, par_err;

  always_comb begin
    start_edge = rxs_d & ~rxs;
    nbits      = 4'd7 + {3'b000, cfg.eight} + {3'b000, cfg.pen};
    half_tc    = (cnt == ((cfg.baud >> 1) - CNT_ONE));
    bit_tc     = (cnt == (cfg.baud - CNT_ONE));
    last_bit   = (bcnt == (nbits - 4'd1));
    // samples enter at bit 8 and shift right, so the first received bit
    // sits at position 9-N once N samples are in
    aligned    = sr >> (4'd9 - nbits);
    data_w     = cfg.eight ? aligned[7:0] : {1'b0, aligned[6:0]};
    par_bit    = cfg.eight ? aligned[8] : aligned[7];
    par_err    = cfg.pen & ((^data_w ^ par_bit) != cfg.ohel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cfg      <= '0;
      cnt      <= '0;
      bcnt     <= '0;
      sr       <= '0;
      stop_bit <= 1'b1;
      rx_data  <= 8'h00;
      rx_rdy   <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      // a commit later in this block overrides the acknowledge
      if (rd_ack) rx_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt  <= '0;
          bcnt <= '0;
          busy <= 1'b0;
          if (start_edge) begin
            cfg   <= '{baud: baud_val, eight: eight, pen: pen, ohel: ohel};
            state <= S_START;
            busy  <= 1'b1;
          end
        end
        S_START: begin
          if (half_tc) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
            end else begin
              // line back high at mid-start: glitch, drop silently
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_tc) begin
            cnt <= '0;
            sr  <= {rxs, sr[8:1]};
            if (last_bit) state <= S_STOP;
            else          bcnt  <= bcnt + 4'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_tc) begin
            cnt      <= '0;
            stop_bit <= rxs;
            state    <= S_COMMIT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_COMMIT: begin
          rx_data <= data_w;
          ferr    <= ~stop_bit;
          perr    <= par_err;
          ovf     <= rx_rdy & ~rd_ack;
          rx_rdy  <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine
//   Directed bench for uart_rx_engine: a table of single frames covering the
//   data-width/parity combinations, plus hand sequences for exact latency,
//   framing error with a held-low line, glitch rejection, overrun with and
//   without a same-cycle acknowledge, and reset mid-frame.
module tb_uart_rx_engine;

  localparam int DIV_W = 19;
  localparam int BAUD  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic [DIV_W-1:0] baud_val;
  logic             eight, pen, ohel, rd_ack;
  logic [7:0]       rx_data;
  logic             rx_rdy, perr, ferr, ovf, busy;

  int checks   = 0;
  int failures = 0;

  uart_rx_engine #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_val(baud_val),
    .eight(eight), .pen(pen), .ohel(ohel), .rd_ack(rd_ack),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .perr(perr), .ferr(ferr),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       eight, pen, ohel;
    logic [8:0] pl;      // data bits then parity bit, LSB first
    int         n;       // bits after the start bit, before stop
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // call #1 after a rising edge; the next rising edge is cycle 0 of the frame
  task automatic send(input logic [8:0] pl, input int n, input logic stop);
    logic [11:0] w;
    w    = '1;
    w[0] = 1'b0;
    for (int i = 0; i < n; i++) w[i+1] = pl[i];
    w[n+1] = stop;
    for (int i = 0; i < n + 2; i++) begin
      rx = w[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
  endtask

  task automatic cfg(input logic e, input logic p, input logic o);
    eight = e; pen = p; ohel = o;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 9'h0A5, 8, 1'b1, 8'hA5, 1'b0}; // 8N1
    vt[1] = '{1'b0, 1'b1, 1'b0, 9'h0C1, 8, 1'b1, 8'h41, 1'b1}; // 7E1 par=1
    vt[2] = '{1'b0, 1'b1, 1'b0, 9'h041, 8, 1'b1, 8'h41, 1'b0}; // 7E1 par=0
    vt[3] = '{1'b0, 1'b1, 1'b1, 9'h0C1, 8, 1'b1, 8'h41, 1'b0}; // 7O1 par=1
    vt[4] = '{1'b1, 1'b1, 1'b0, 9'h0FF, 9, 1'b1, 8'hFF, 1'b0}; // 8E1 par=0
    vt[5] = '{1'b1, 1'b1, 1'b1, 9'h180, 9, 1'b1, 8'h80, 1'b1}; // 8O1 par=1
    vt[6] = '{1'b0, 1'b0, 1'b0, 9'h07F, 7, 1'b1, 8'h7F, 1'b0}; // 7N1
    vt[7] = '{1'b1, 1'b1, 1'b1, 9'h080, 9, 1'b1, 8'h80, 1'b0}; // 8O1 par=0

    rst = 1'b1; rx = 1'b1; rd_ack = 1'b0; baud_val = BAUD[DIV_W-1:0];
    cfg(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk("reset rx_data", {24'd0, rx_data}, 32'h00);
    chk("reset rx_rdy", {31'd0, rx_rdy}, 32'd0);
    chk("reset flags", {29'd0, perr, ferr, ovf}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;

    // exact latency of an 8N1 frame: commit at 2 + 8 + 9*16 + 1 = 155
    fork
      send(9'h0A5, 8, 1'b1);
      begin
        repeat (4) @(posedge clk); #1;
        chk("lat busy at +3", {31'd0, busy}, 32'd1);
        repeat (151) @(posedge clk); #1;
        chk("lat rdy at +154", {31'd0, rx_rdy}, 32'd0);
        chk("lat busy at +154", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("lat rdy at +155", {31'd0, rx_rdy}, 32'd1);
        chk("lat busy at +155", {31'd0, busy}, 32'd0);
        chk("lat data", {24'd0, rx_data}, 32'hA5);
      end
    join
    rx = 1'b1;
    ack();
    chk("lat ack clears rdy", {31'd0, rx_rdy}, 32'd0);
    chk("lat ack keeps data", {24'd0, rx_data}, 32'hA5);

    // table of single frames
    for (int i = 0; i < 8; i++) begin
      cfg(vt[i].eight, vt[i].pen, vt[i].ohel);
      repeat (4) @(posedge clk); #1;
      send(vt[i].pl, vt[i].n, vt[i].stop);
      rx = 1'b1;
      chk($sformatf("vec%0d data", i), {24'd0, rx_data}, {24'd0, vt[i].exp_data});
      chk($sformatf("vec%0d perr", i), {31'd0, perr}, {31'd0, vt[i].exp_perr});
      chk($sformatf("vec%0d ferr", i), {31'd0, ferr}, 32'd0);
      chk($sformatf("vec%0d ovf", i), {31'd0, ovf}, 32'd0);
      chk($sformatf("vec%0d rdy", i), {31'd0, rx_rdy}, 32'd1);
      ack();
      chk($sformatf("vec%0d ack", i), {31'd0, rx_rdy}, 32'd0);
    end

    // framing error, then the line stays low (break): no retrigger
    cfg(1'b1, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    send(9'h03C, 8, 1'b0);
    chk("ferr flag", {31'd0, ferr}, 32'd1);
    chk("ferr data", {24'd0, rx_data}, 32'h3C);
    chk("ferr rdy", {31'd0, rx_rdy}, 32'd1);
    ack();
    repeat (200) @(posedge clk); #1;
    chk("break no busy", {31'd0, busy}, 32'd0);
    chk("break no rdy", {31'd0, rx_rdy}, 32'd0);
    chk("break ferr held", {31'd0, ferr}, 32'd1);
    rx = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("break release idle", {31'd0, busy}, 32'd0);

    // 5-clock low glitch is rejected at the mid-start sample (edge 10)
    rx = 1'b0;
    repeat (5) @(posedge clk); #1;
    rx = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("glitch busy mid", {31'd0, busy}, 32'd1);
    repeat (10) @(posedge clk); #1;
    chk("glitch busy end", {31'd0, busy}, 32'd0);
    chk("glitch no rdy", {31'd0, rx_rdy}, 32'd0);
    chk("glitch data kept", {24'd0, rx_data}, 32'h3C);

    // back-to-back without ack: overrun on the second commit
    fork
      begin send(9'h011, 8, 1'b1); send(9'h022, 8, 1'b1); end
      begin
        repeat (156) @(posedge clk); #1;
        chk("b2b first data", {24'd0, rx_data}, 32'h11);
        chk("b2b first ovf", {31'd0, ovf}, 32'd0);
      end
    join
    rx = 1'b1;
    chk("b2b second data", {24'd0, rx_data}, 32'h22);
    chk("b2b ovf", {31'd0, ovf}, 32'd1);
    chk("b2b rdy", {31'd0, rx_rdy}, 32'd1);
    ack();
    repeat (4) @(posedge clk); #1;

    // same again with rd_ack in the second commit cycle (edge 315)
    fork
      begin send(9'h033, 8, 1'b1); send(9'h044, 8, 1'b1); end
      begin
        repeat (315) @(posedge clk); #1;
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
        chk("ackcommit data", {24'd0, rx_data}, 32'h44);
        chk("ackcommit ovf", {31'd0, ovf}, 32'd0);
        chk("ackcommit rdy", {31'd0, rx_rdy}, 32'd1);
      end
    join
    rx = 1'b1;
    ack();

    // reset during DATA bit 4-5, held until the wire frame has ended
    repeat (4) @(posedge clk); #1;
    fork
      send(9'h0C3, 8, 1'b1);
      begin
        repeat (80) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst data", {24'd0, rx_data}, 32'h00);
        chk("midrst rdy", {31'd0, rx_rdy}, 32'd0);
      end
    join
    rx = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst no commit", {31'd0, rx_rdy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("post-rst idle", {31'd0, busy}, 32'd0);
    send(9'h05A, 8, 1'b1);
    rx = 1'b1;
    chk("post-rst data", {24'd0, rx_data}, 32'h5A);
    chk("post-rst rdy", {31'd0, rx_rdy}, 32'd1);
    chk("post-rst flags", {29'd0, perr, ferr, ovf}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receive engine that combines receive control, bit timing, shifting and error checking in one block. It adds runtime-selectable baud divisor, 7/8 data bits, optional even/odd parity, mid-bit start validation, and framing, parity and overrun error flags. It sits between the serial `rx` pin and the processor-side receive data register, and exposes a level-ready/acknowledge read handshake.

## Interface
- `DIV_W`, 19: width of the baud divisor and the bit-time counter.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial line, asynchronous to `clk`, idles high.
- `baud_val`  in  DIV_W  clocks per bit; legal values are 4 to 2^DIV_W−1.
- `eight`  in  1  1 selects 8 data bits, 0 selects 7.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 is odd, 0 is even.
- `rd_ack`  in  1  one-cycle pulse that consumes the held frame.
- `rx_data`  out  8  received byte, LSB first on the wire; bit 7 reads 0 in 7-bit mode.
- `rx_rdy`  out  1  a frame is held and unread.
- `perr`, `ferr`, `ovf`  out  1 each  parity, framing and overrun flags for the held frame.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser to give `rxs`, plus one history flop `rxs_d`.
- A start edge is `rxs_d==1 && rxs==0` while in IDLE. Continuous low, such as a break, does not retrigger.
- `eight`, `pen`, `ohel` and `baud_val` are latched at the start edge and held for the whole frame.
- The bit count is N = 7 + `eight` + `pen`.
- States:
  - IDLE: clear the counters. On a start edge, go to START.
  - START: count `baud_val>>1` clocks to reach the mid-bit sample point.
    - If `rxs==0` there, go to DATA and reload the counter.
    - If `rxs==1`, treat it as a glitch and return to IDLE with no flags changed.
  - DATA: sample `rxs` every `baud_val` clocks and shift right into a 9-bit shift register. After N samples, go to STOP.
  - STOP: sample once after `baud_val` clocks, commit the frame, then return to IDLE on the next cycle.
- Commit happens in the cycle after the stop sample:
  - `rx_data` loads the data bits.
  - `ferr` = (stop sample == 0).
  - `perr` is 1 when `pen` is set and the XOR of the data and parity bits does not equal `ohel`; otherwise 0.
  - `ovf` = `rx_rdy` was already 1 and `rd_ack` is not asserted in the commit cycle.
  - `rx_rdy` is set to 1.
- `rd_ack` clears `rx_rdy`. It has no effect on `rx_data`, `perr`, `ferr` or `ovf`; the flags change only at the next commit.
- If `rd_ack` and a commit occur in the same cycle, the commit wins: `rx_rdy` stays 1 and `ovf` = 0.
- On overrun, the new frame overwrites `rx_data`.
- An illegal state value forces IDLE.

## Timing
- Reset values: `rx_data`=0x00, `rx_rdy`=0, `perr`=0, `ferr`=0, `ovf`=0, `busy`=0, state IDLE, synchroniser flops=1.
- Reset asserted mid-frame aborts the frame immediately. Nothing is committed, and the next start edge is needed after release.
- Latency is measured from `rx` falling (set up before a `clk` edge):
  - Start edge detected at cycle +2; `busy`=1 from cycle +3.
  - START sample at +2+(`baud_val>>1`).
  - DATA sample k (k = 1..N) at START sample + k·`baud_val`.
  - Stop sample at START sample + (N+1)·`baud_val`.
  - `rx_rdy` and flags valid one cycle after the stop sample; `busy`=0 in that same cycle.
- A new start edge is accepted from the first IDLE cycle. This allows back-to-back frames with a tolerance of up to half a bit.
- The counter is DIV_W bits wide and terminal-count compares exactly, so it has no wrap-around dependence.

## Test plan
- `baud_val`=16, `eight`=1, `pen`=0, frame 0xA5 (8N1) -> `rx_data`=0xA5, `rx_rdy`=1 at the computed cycle, `perr`=`ferr`=`ovf`=0; then `rd_ack` -> `rx_rdy`=0.
- `baud_val`=16, 7E1 (`eight`=0, `pen`=1, `ohel`=0), data 0x41 with parity bit 1 -> `rx_data`=0x41, `perr`=1. Repeat with parity bit 0 -> `perr`=0. Repeat 7O1 with parity bit 1 -> `perr`=0.
- 8N1 frame 0x3C with the stop bit driven 0 -> `ferr`=1, `rx_data`=0x3C. With `rx` held low afterwards, no new frame starts until `rx` goes high and falls again.
- `rx` low pulse of 5 clocks at `baud_val`=16 -> START rejects it, `busy` returns to 0, `rx_rdy` stays 0.
- Two back-to-back 8N1 frames 0x11 then 0x22 with no `rd_ack` -> second commit gives `rx_data`=0x22, `ovf`=1. Repeat with `rd_ack` in the second commit cycle -> `ovf`=0, `rx_rdy`=1.
- Assert `rst` during DATA bit 4 of a frame -> all outputs at reset values, no commit. After release, a clean 0x5A frame is received correctly.
